// File: rtl/cw_pkg.sv
// Control-word layout shared by the decoders and the execute stage:
// field offsets, widths, PC-select encodings and a packed view of the word.
package cw_pkg;

  localparam int CW_WIDTH   = 29;

  localparam int PSEL_LSB   = 27;
  localparam int PSEL_W     = 2;
  localparam int DA_LSB     = 22;
  localparam int SA_LSB     = 17;
  localparam int SB_LSB     = 12;
  localparam int REG_ADDR_W = 5;
  localparam int FSEL_LSB   = 7;
  localparam int FSEL_W     = 5;
  localparam int REGW_BIT   = 6;
  localparam int RAMW_BIT   = 5;
  localparam int DSEL_LSB   = 3;
  localparam int DSEL_W     = 2;
  localparam int BSEL_BIT   = 2;
  localparam int PCSEL_BIT  = 1;
  localparam int SL_BIT     = 0;

  typedef enum logic [PSEL_W-1:0] {
    PSEL_HOLD = 2'b00,
    PSEL_INC  = 2'b01,
    PSEL_LOAD = 2'b10,
    PSEL_REL  = 2'b11
  } psel_e;

  typedef struct packed {
    logic [PSEL_W-1:0]     psel;
    logic [REG_ADDR_W-1:0] da;
    logic [REG_ADDR_W-1:0] sa;
    logic [REG_ADDR_W-1:0] sb;
    logic [FSEL_W-1:0]     fsel;
    logic                  regw;
    logic                  ramw;
    logic [DSEL_W-1:0]     dsel;
    logic                  bsel;
    logic                  pcsel;
    logic                  sl;
  } cw_t;

  // Word offset for relative branches: operand scaled by 4, top 2 bits dropped.
  function automatic logic [63:0] rel_offset(input logic [63:0] v);
    return {v[61:0], 2'b00};
  endfunction

endpackage

// File: rtl/cw_executor_pc_unit.sv
// Program counter with Psel next-PC mux and optional load-target alignment
// check. Alignment checking is compiled in with CW_EXEC_ALIGN_CHECK_EN.
module pc_unit
  import cw_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_xfer,
  input  psel_e       i_psel,
  input  logic [63:0] i_in,
  output logic [63:0] o_pc,
  output logic        o_drop,
  output logic        o_fault
);

  logic [63:0] r_pc;
  logic [63:0] w_pc_next;

  // Next-PC selection; all sums wrap modulo 2^64.
  always_comb begin
    w_pc_next = r_pc;
    case (i_psel)
      PSEL_HOLD: w_pc_next = r_pc;
      PSEL_INC:  w_pc_next = r_pc + 64'd4;
      PSEL_LOAD: w_pc_next = i_in;
      PSEL_REL:  w_pc_next = r_pc + rel_offset(i_in);
      default:   w_pc_next = r_pc;
    endcase
  end

`ifdef CW_EXEC_ALIGN_CHECK_EN
  logic r_fault;

  assign o_drop = (i_psel == PSEL_LOAD) && (i_in[1:0] != 2'b00);

  // Sticky fault on the first misaligned absolute jump; cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset)
      r_fault <= 1'b0;
    else if (i_xfer && o_drop)
      r_fault <= 1'b1;
  end

  assign o_fault = r_fault;
`else
  assign o_drop  = 1'b0;
  assign o_fault = 1'b0;
`endif

  // PC register: advances only on an accepted, non-dropped word.
  always_ff @(posedge clock) begin
    if (reset)
      r_pc <= PC_RESET;
    else if (i_xfer && !o_drop)
      r_pc <= w_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cw_executor.sv
// Execute-stage consumer of the decoder control word: execute register,
// decoder state register, write-strobe gating; PC lives in pc_unit.
// Optional misaligned-jump fault: define CW_EXEC_ALIGN_CHECK_EN.
module cw_executor
  import cw_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cw_valid,
  output logic                  cw_ready,
  input  logic [CW_WIDTH-1:0]   controlWord,
  input  logic [1:0]            nextState,
  input  logic [63:0]           K,
  input  logic [63:0]           busA,
  input  logic                  ex_stall,
  output logic [63:0]           pc,
  output logic [1:0]            state,
  output logic [REG_ADDR_W-1:0] ex_DA,
  output logic [REG_ADDR_W-1:0] ex_SA,
  output logic [REG_ADDR_W-1:0] ex_SB,
  output logic [FSEL_W-1:0]     ex_Fsel,
  output logic [DSEL_W-1:0]     ex_Dsel,
  output logic                  ex_Bsel,
  output logic                  ex_SL,
  output logic [63:0]           ex_K,
  output logic                  reg_we,
  output logic                  ram_we,
  output logic                  fault
);

  cw_t         r_cw;
  logic [63:0] r_k;
  logic        r_valid;
  logic [1:0]  r_state;

  logic        w_xfer;
  logic        w_drop;
  logic        w_fault;
  psel_e       w_psel;
  logic [63:0] w_in;

  assign cw_ready = ~ex_stall & ~w_fault;
  assign w_xfer   = cw_valid & cw_ready;
  assign w_psel   = psel_e'(controlWord[PSEL_LSB +: PSEL_W]);
  assign w_in     = controlWord[PCSEL_BIT] ? busA : K;

  pc_unit #(
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clock   (clock),
    .reset   (reset),
    .i_xfer  (w_xfer),
    .i_psel  (w_psel),
    .i_in    (w_in),
    .o_pc    (pc),
    .o_drop  (w_drop),
    .o_fault (w_fault)
  );

  // Execute register: load on transfer, freeze on stall, otherwise go idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cw    <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
    end else if (ex_stall) begin
      r_cw    <= r_cw;
      r_k     <= r_k;
      r_valid <= r_valid;
    end else if (w_xfer && !w_drop) begin
      r_cw    <= cw_t'(controlWord);
      r_k     <= K;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Decoder state tracks nextState of each accepted word.
  always_ff @(posedge clock) begin
    if (reset)
      r_state <= 2'b00;
    else if (w_xfer && !w_drop)
      r_state <= nextState;
  end

  assign state   = r_state;
  assign ex_DA   = r_cw.da;
  assign ex_SA   = r_cw.sa;
  assign ex_SB   = r_cw.sb;
  assign ex_Fsel = r_cw.fsel;
  assign ex_Dsel = r_cw.dsel;
  assign ex_Bsel = r_cw.bsel;
  assign ex_SL   = r_cw.sl;
  assign ex_K    = r_k;
  assign fault   = w_fault;

  // Strobes drop combinationally while stalled and re-assert when it clears.
  assign reg_we  = r_valid & r_cw.regw & ~ex_stall;
  assign ram_we  = r_valid & r_cw.ramw & ~ex_stall;

  // PC-path fields are consumed before latching; kept in cw_q for visibility.
  logic w_unused_cw;
  assign w_unused_cw = ^{r_cw.psel, r_cw.pcsel};

endmodule

// File: tb/tb_cw_executor.sv
// Self-checking bench for cw_executor (PC_RESET = 0x40). Expected results
// are queued when a word is driven and popped when the DUT reflects it.
`timescale 1ns/1ps
module tb_cw_executor;

  logic        clock, reset, cw_valid, cw_ready, ex_stall;
  logic [28:0] controlWord;
  logic [1:0]  nextState, state, ex_Dsel;
  logic [63:0] K, busA, pc, ex_K;
  logic [4:0]  ex_DA, ex_SA, ex_SB, ex_Fsel;
  logic        ex_Bsel, ex_SL, reg_we, ram_we, fault;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  state;
    logic        reg_we;
    logic        ram_we;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  cw_executor #(.PC_RESET(64'h40)) dut (
    .clock(clock), .reset(reset), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .controlWord(controlWord), .nextState(nextState), .K(K), .busA(busA),
    .ex_stall(ex_stall), .pc(pc), .state(state), .ex_DA(ex_DA), .ex_SA(ex_SA),
    .ex_SB(ex_SB), .ex_Fsel(ex_Fsel), .ex_Dsel(ex_Dsel), .ex_Bsel(ex_Bsel),
    .ex_SL(ex_SL), .ex_K(ex_K), .reg_we(reg_we), .ram_we(ram_we), .fault(fault)
  );

  always #5 clock = ~clock;

  // DA=1 SA=2 SB=3 Fsel=4 Dsel=10 Bsel=1 SL=0
  function automatic logic [28:0] mk_cw(input logic [1:0] ps, input logic rw,
                                        input logic mw, input logic pcs);
    return {ps, 5'd1, 5'd2, 5'd3, 5'd4, rw, mw, 2'b10, 1'b1, pcs, 1'b0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_word(input logic [28:0] cw, input logic [1:0] ns,
                            input logic [63:0] k, input logic [63:0] a);
    cw_valid = 1'b1; controlWord = cw; nextState = ns; K = k; busA = a;
  endtask

  task automatic do_reset();
    cw_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pc !== 64'h40) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", pc, 64'h40); end
    n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b expected 00", state); end
    n_checks++; if ({reg_we, ram_we} !== 2'b00) begin n_errors++; $display("FAIL reset_strobes: got %b expected 00", {reg_we, ram_we}); end
    n_checks++; if (cw_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", cw_ready); end
    n_checks++; if (ex_K !== 64'h0) begin n_errors++; $display("FAIL reset_exK: got %h expected 0", ex_K); end
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
  endtask

  task automatic test_branch();
    exp_t e;
    drive_word(mk_cw(2'b11, 1'b0, 1'b0, 1'b1), 2'b00, 64'h5, 64'h1000);
    sb_q.push_back('{64'h4040, 2'b00, 1'b0, 1'b0});
    step();
    cw_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++; if (pc !== e.pc) begin n_errors++; $display("FAIL br_pc: got %h expected %h", pc, e.pc); end
    n_checks++; if (state !== e.state) begin n_errors++; $display("FAIL br_state: got %b expected %b", state, e.state); end
    n_checks++; if ({reg_we, ram_we} !== {e.reg_we, e.ram_we}) begin n_errors++; $display("FAIL br_strobes: got %b expected 00", {reg_we, ram_we}); end
    n_checks++; if (ex_K !== 64'h5) begin n_errors++; $display("FAIL br_exK: got %h expected 5", ex_K); end
    n_checks++; if ({ex_DA, ex_SA, ex_SB, ex_Fsel} !== {5'd1, 5'd2, 5'd3, 5'd4}) begin n_errors++; $display("FAIL br_fields: got %h expected %h", {ex_DA, ex_SA, ex_SB, ex_Fsel}, {5'd1, 5'd2, 5'd3, 5'd4}); end
    n_checks++; if ({ex_Dsel, ex_Bsel, ex_SL} !== 4'b1010) begin n_errors++; $display("FAIL br_ctl: got %b expected 1010", {ex_Dsel, ex_Bsel, ex_SL}); end
    step();
    n_checks++; if (pc !== 64'h4040) begin n_errors++; $display("FAIL br_hold_pc: got %h expected 4040", pc); end
  endtask

  task automatic test_rel_k_and_wrap();
    exp_t e;
    logic [28:0] cws [4];
    logic [63:0] ks  [4];
    logic [63:0] pcs [4];
    cws[0] = mk_cw(2'b10, 1'b0, 1'b0, 1'b0); ks[0] = 64'h100;                pcs[0] = 64'h100;
    cws[1] = mk_cw(2'b11, 1'b0, 1'b0, 1'b0); ks[1] = 64'h3;                  pcs[1] = 64'h10C;
    cws[2] = mk_cw(2'b10, 1'b0, 1'b0, 1'b0); ks[2] = 64'hFFFF_FFFF_FFFF_FFFC; pcs[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    cws[3] = mk_cw(2'b01, 1'b0, 1'b0, 1'b0); ks[3] = 64'h7;                  pcs[3] = 64'h0;
    for (int i = 0; i < 4; i++) begin
      drive_word(cws[i], 2'b00, ks[i], 64'hDEAD_0001);
      sb_q.push_back('{pcs[i], 2'b00, 1'b0, 1'b0});
      step();
      cw_valid = 1'b0;
      e = sb_q.pop_front();
      n_checks++; if (pc !== e.pc) begin n_errors++; $display("FAIL relk_pc[%0d]: got %h expected %h", i, pc, e.pc); end
      n_checks++; if (ex_K !== ks[i]) begin n_errors++; $display("FAIL relk_exK[%0d]: got %h expected %h", i, ex_K, ks[i]); end
    end
  endtask

  task automatic test_stall_strobe();
    exp_t e;
    int   hi_cycles;
    drive_word(mk_cw(2'b00, 1'b1, 1'b0, 1'b0), 2'b10, 64'h9, 64'h0);
    sb_q.push_back('{64'h0, 2'b10, 1'b1, 1'b0});
    step();
    // stall raised during N+1, with another word offered that must not be taken
    ex_stall = 1'b1;
    drive_word(mk_cw(2'b01, 1'b0, 1'b0, 1'b0), 2'b01, 64'h1, 64'h0);
    #1;
    n_checks++; if (reg_we !== 1'b0) begin n_errors++; $display("FAIL stall_we0: got %b expected 0", reg_we); end
    n_checks++; if (cw_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready: got %b expected 0", cw_ready); end
    step();
    n_checks++; if (reg_we !== 1'b0) begin n_errors++; $display("FAIL stall_we1: got %b expected 0", reg_we); end
    n_checks++; if (pc !== 64'h0) begin n_errors++; $display("FAIL stall_pc: got %h expected 0", pc); end
    n_checks++; if (state !== 2'b10) begin n_errors++; $display("FAIL stall_state: got %b expected 10", state); end
    step();
    cw_valid = 1'b0;
    ex_stall = 1'b0;
    #1;
    e = sb_q.pop_front();
    hi_cycles = 0;
    if (reg_we === 1'b1) hi_cycles++;
    n_checks++; if ({reg_we, ram_we} !== {e.reg_we, e.ram_we}) begin n_errors++; $display("FAIL stall_release: got %b expected %b", {reg_we, ram_we}, {e.reg_we, e.ram_we}); end
    n_checks++; if (pc !== e.pc || state !== e.state) begin n_errors++; $display("FAIL stall_frozen: got %h/%b expected %h/%b", pc, state, e.pc, e.state); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (reg_we === 1'b1) hi_cycles++;
    end
    n_checks++; if (hi_cycles !== 1) begin n_errors++; $display("FAIL stall_one_strobe: got %0d expected 1", hi_cycles); end
  endtask

  task automatic test_multicycle();
    exp_t e;
    drive_word(mk_cw(2'b00, 1'b1, 1'b0, 1'b0), 2'b01, 64'h0, 64'h0);
    sb_q.push_back('{64'h0, 2'b01, 1'b1, 1'b0});
    step();
    e = sb_q.pop_front();
    n_checks++; if (state !== e.state || pc !== e.pc) begin n_errors++; $display("FAIL mc_first: got %h/%b expected %h/%b", pc, state, e.pc, e.state); end
    n_checks++; if (reg_we !== e.reg_we) begin n_errors++; $display("FAIL mc_first_we: got %b expected %b", reg_we, e.reg_we); end
    drive_word(mk_cw(2'b01, 1'b0, 1'b1, 1'b0), 2'b00, 64'h0, 64'h0);
    sb_q.push_back('{64'h4, 2'b00, 1'b0, 1'b1});
    step();
    cw_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++; if (state !== e.state || pc !== e.pc) begin n_errors++; $display("FAIL mc_second: got %h/%b expected %h/%b", pc, state, e.pc, e.state); end
    n_checks++; if ({reg_we, ram_we} !== {e.reg_we, e.ram_we}) begin n_errors++; $display("FAIL mc_second_we: got %b expected %b", {reg_we, ram_we}, {e.reg_we, e.ram_we}); end
    drive_word(mk_cw(2'b00, 1'b1, 1'b0, 1'b0), 2'b01, 64'h0, 64'h0);
    step();
    n_checks++; if (state !== 2'b01) begin n_errors++; $display("FAIL mc_third_state: got %b expected 01", state); end
    // reset wins over a word offered in the same cycle
    drive_word(mk_cw(2'b01, 1'b1, 1'b0, 1'b0), 2'b11, 64'h0, 64'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cw_valid = 1'b0;
    n_checks++; if (state !== 2'b00) begin n_errors++; $display("FAIL mc_reset_state: got %b expected 00", state); end
    n_checks++; if (reg_we !== 1'b0 || ex_DA !== 5'd0) begin n_errors++; $display("FAIL mc_reset_valid: got we=%b DA=%0d expected we=0 DA=0", reg_we, ex_DA); end
    n_checks++; if (pc !== 64'h40) begin n_errors++; $display("FAIL mc_reset_pc: got %h expected 40", pc); end
  endtask

  task automatic test_align();
    do_reset();
    drive_word(mk_cw(2'b10, 1'b1, 1'b0, 1'b1), 2'b01, 64'h0, 64'h1002);
    step();
    cw_valid = 1'b0;
`ifdef CW_EXEC_ALIGN_CHECK_EN
    n_checks++; if (pc !== 64'h40) begin n_errors++; $display("FAIL align_pc: got %h expected 40", pc); end
    n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL align_fault: got %b expected 1", fault); end
    n_checks++; if (cw_ready !== 1'b0 || reg_we !== 1'b0) begin n_errors++; $display("FAIL align_ready: got rdy=%b we=%b expected 0/0", cw_ready, reg_we); end
    drive_word(mk_cw(2'b01, 1'b0, 1'b0, 1'b0), 2'b00, 64'h0, 64'h0);
    step();
    cw_valid = 1'b0;
    n_checks++; if (pc !== 64'h40 || fault !== 1'b1) begin n_errors++; $display("FAIL align_sticky: got %h/%b expected 40/1", pc, fault); end
    do_reset();
    n_checks++; if (fault !== 1'b0 || cw_ready !== 1'b1) begin n_errors++; $display("FAIL align_clear: got %b/%b expected 0/1", fault, cw_ready); end
`else
    n_checks++; if (pc !== 64'h1002) begin n_errors++; $display("FAIL align_pc: got %h expected 1002", pc); end
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL align_fault: got %b expected 0", fault); end
    n_checks++; if (reg_we !== 1'b1 || cw_ready !== 1'b1) begin n_errors++; $display("FAIL align_accept: got we=%b rdy=%b expected 1/1", reg_we, cw_ready); end
`endif
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; cw_valid = 1'b0; ex_stall = 1'b0;
    controlWord = '0; nextState = '0; K = '0; busA = '0;
    n_checks = 0; n_errors = 0;
    test_reset();
    test_branch();
    test_rel_k_and_wrap();
    test_stall_strobe();
    test_multicycle();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cw_executor.md
# cw_executor

Execute-stage consumer of the 29-bit control word produced by the per-opcode instruction decoders (BR and siblings). Accepts one control word per cycle with its `nextState` and `K` constant, latches it into an execute register, unpacks the fields for the datapath, owns the program counter and the 2-bit decoder state register, and gates register/RAM write strobes. It sits between the decoder mux and the register file/ALU/RAM datapath.

## Interface
Parameters:
- `PC_RESET`, 64'd0, PC value loaded on reset.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `cw_valid`  in  1  decoder outputs are valid this cycle.
- `cw_ready`  out  1  executor accepts this cycle; transfer = `cw_valid & cw_ready`.
- `controlWord`  in  29  `{Psel[28:27], DA[26:22], SA[21:17], SB[16:12], Fsel[11:7], regW[6], ramW[5], Dsel[4:3], Bsel[2], PCsel[1], SL[0]}`.
- `nextState`  in  2  decoder state for the next cycle.
- `K`  in  64  constant from the decoder.
- `busA`  in  64  register-file A output (read at `controlWord.SA`, same cycle).
- `ex_stall`  in  1  downstream (RAM) stall.
- `pc`  out  64  current program counter.
- `state`  out  2  decoder state register, fed back to the decoders.
- `ex_DA, ex_SA, ex_SB, ex_Fsel`  out  5 each  latched fields.
- `ex_Dsel`  out  2; `ex_Bsel, ex_SL`  out  1  latched fields.
- `ex_K`  out  64  latched constant.
- `reg_we, ram_we`  out  1  write strobes, one cycle per accepted word.
- `fault`  out  1  sticky misalignment fault (0 when feature compiled out).

## Operation
- `cw_ready = ~ex_stall & ~fault`.
- On transfer: `cw_q <= controlWord`, `K_q <= K`, `valid_q <= 1`, `state <= nextState`, PC updated per Psel. No transfer: `valid_q <= 0` unless `ex_stall` (then hold `cw_q/K_q/valid_q`).
- Operand `in = PCsel ? busA : K`.
- Psel: 00 hold; 01 `pc + 4`; 10 `pc <= in`; 11 `pc + (in << 2)`. All arithmetic 64-bit, modulo 2^64; `in << 2` drops the top 2 bits.
- `reg_we = valid_q & regW_q & ~ex_stall`; `ram_we = valid_q & ramW_q & ~ex_stall`.
- `ex_*` always reflect `cw_q`/`K_q`; meaningful only while `valid_q`.
- Multi-cycle instructions: decoder sees the same instruction with `state != 0`; executor simply tracks `nextState`. The decoder sets Psel=00 on non-final states.
- Stall: PC, state, `cw_q` frozen; write strobes low.

## Timing
- Reset values: `pc = PC_RESET`, `state = 0`, `valid_q = 0`, `cw_q = 0`, `K_q = 0`, `reg_we = ram_we = 0`, `fault = 0`, `cw_ready = 1` (when `ex_stall` low).
- Transfer at edge N: new `pc`/`state` and `ex_*` visible after N; strobes asserted during cycle N+1 (one cycle) unless stalled.
- Stall raised mid-cycle N+1: strobes drop combinationally and re-assert when the stall clears. Each accepted word yields exactly one strobe cycle.
- Reset overrides transfer and stall in the same cycle.
- `cw_valid` low: PC, state hold.

## Configuration
- `CW_EXEC_ALIGN_CHECK_EN` defined: on transfer with Psel=10 and `in[1:0] != 0`, PC is not updated, the word is dropped (`valid_q <= 0`), `fault <= 1` (sticky until reset), `cw_ready` drops the next cycle.
- Undefined: no check; `fault` tied 0; misaligned targets load as-is.

## Structure
- Package `cw_pkg`: field bit offsets/widths, `CW_WIDTH = 29`, Psel encodings (`PSEL_HOLD, PSEL_INC, PSEL_LOAD, PSEL_REL`).
- Sub-module `pc_unit`: PC register, Psel mux, adder, alignment check; `cw_executor` holds execute register, state, strobes.

## Test plan
- Reset with `PC_RESET = 0x40` -> `pc = 0x40`, `state = 0`, strobes 0, `cw_ready = 1`.
- BR word (Psel=11, PCsel=1, regW=0), `busA = 0x1000`, `pc = 0x40` -> `pc = 0x4040`; `reg_we`, `ram_we` stay 0.
- Psel=11, PCsel=0, `K = 3`, `pc = 0x100` -> `pc = 0x10C`; Psel=01 at `pc = 0xFFFF_FFFF_FFFF_FFFC` -> `pc = 0`.
- regW=1 word accepted with `ex_stall` high for 2 cycles during N+1 -> `reg_we` low for 2 cycles, then exactly one high cycle; PC/state frozen.
- Two-cycle op: `nextState = 01` (Psel=00) then `00` (Psel=01) -> `state` 01 then 00; PC changes only after second word; reset asserted between them -> `state = 0`, `valid_q = 0`.
- With macro: Psel=10, `busA = 0x1002` -> `pc` unchanged, `fault = 1`, `cw_ready = 0` until reset; without macro -> `pc = 0x1002`, `fault = 0`.
